// File: rtl/cvxif_complex_pkg.sv
// Shared types and decode helpers for the complex-number CVXIF coprocessor.
// Optional multiply support is enabled by defining CVXIF_CPLX_MUL_EN.
package cvxif_complex_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_CONJ = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_e;

  localparam logic [6:0] CPLX_OPCODE = 7'b1111011;
  localparam logic [6:0] CPLX_FUNC7  = 7'b0000000;

  // Widest instruction tag a pending entry can hold; narrower tags are zero-extended.
  localparam int PEND_ID_MAX = 16;

  typedef struct packed {
    op_e                    op;
    logic [PEND_ID_MAX-1:0] id;
  } pending_t;

  function automatic logic instr_match(input logic [31:0] instr);
    logic base_ok;
    base_ok = (instr[6:0] == CPLX_OPCODE) && (instr[31:25] == CPLX_FUNC7);
`ifdef CVXIF_CPLX_MUL_EN
    return base_ok && (instr[14:12] <= 3'b011);
`else
    return base_ok && (instr[14:12] <= 3'b010);
`endif
  endfunction

  // conj only reads rs1; every other operation needs both sources.
  function automatic logic [1:0] read_mask(input op_e op);
    return (op == OP_CONJ) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/cvxif_cplx_alu.sv
// Combinational complex ALU: per-component arithmetic modulo 2^(XLEN/2).
// The multiplier is only built when CVXIF_CPLX_MUL_EN is defined.
module cvxif_cplx_alu
  import cvxif_complex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_e             op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result
);

  localparam int H = XLEN / 2;

  logic [H-1:0] ar, ai, br, bi, re, im;

  assign ar = rs1[XLEN-1:H];
  assign ai = rs1[H-1:0];
  assign br = rs2[XLEN-1:H];
  assign bi = rs2[H-1:0];

  always_comb begin
    re = '0;
    im = '0;
    case (op)
      OP_ADD: begin
        re = ar + br;
        im = ai + bi;
      end
      OP_CONJ: begin
        re = ar;
        im = -ai;
      end
      OP_SUB: begin
        re = ar - br;
        im = ai - bi;
      end
`ifdef CVXIF_CPLX_MUL_EN
      // H-bit context keeps only the low H bits of each product sum.
      OP_MUL: begin
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
      end
`endif
      default: begin
        re = '0;
        im = '0;
      end
    endcase
    result = {re, im};
  end

endmodule

// File: rtl/cvxif_complex_mq.sv
// Multi-outstanding complex coprocessor: pending-instruction queue, ALU and result FIFO.
// Define CVXIF_CPLX_MUL_EN to accept and execute the multiply instruction.
module cvxif_complex_mq
  import cvxif_complex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [31:0]          issue_req_instr,
  input  logic [ID_W-1:0]      issue_req_id,
  output logic                 issue_resp_accept,
  output logic                 issue_resp_writeback,
  output logic [1:0]           issue_resp_register_read,
  input  logic                 register_valid,
  output logic                 register_ready,
  input  logic [ID_W-1:0]      register_id,
  input  logic [1:0][XLEN-1:0] register_rs,
  input  logic [1:0]           register_rs_valid,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [XLEN-1:0]      result_data,
  output logic [ID_W-1:0]      result_id,
  output logic                 err_id
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pending_t               pq_mem [DEPTH];
  logic [PW-1:0]          pq_rd, pq_wr;
  logic [CW-1:0]          pq_cnt;

  logic [XLEN-1:0]        rf_data [DEPTH];
  logic [PEND_ID_MAX-1:0] rf_id   [DEPTH];
  logic [PW-1:0]          rf_rd, rf_wr;
  logic [CW-1:0]          rf_cnt;

  pending_t               head;
  op_e                    issue_op;
  logic [1:0]             head_mask;
  logic                   issue_fire, reg_fire, res_pop;
  logic [XLEN-1:0]        alu_res;

  assign issue_op                 = op_e'(issue_req_instr[13:12]);
  assign issue_ready              = pq_cnt < DEPTH_C;
  assign issue_fire               = issue_valid && issue_ready && instr_match(issue_req_instr);
  assign issue_resp_accept        = issue_fire;
  assign issue_resp_writeback     = 1'b1;
  assign issue_resp_register_read = issue_fire ? read_mask(issue_op) : 2'b00;

  // Operands are consumed only once every source the head op needs is valid.
  assign head           = pq_mem[pq_rd];
  assign head_mask      = read_mask(head.op);
  assign register_ready = (pq_cnt != '0) && (rf_cnt < DEPTH_C);
  assign reg_fire       = register_valid && register_ready
                          && ((register_rs_valid & head_mask) == head_mask);

  assign result_valid = rf_cnt != '0;
  assign res_pop      = result_valid && result_ready;
  assign result_data  = rf_data[rf_rd];
  assign result_id    = rf_id[rf_rd][ID_W-1:0];

  cvxif_cplx_alu #(.XLEN(XLEN)) u_alu (
    .op     (head.op),
    .rs1    (register_rs[0]),
    .rs2    (register_rs[1]),
    .result (alu_res)
  );

  // Queue storage needs no reset: pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (issue_fire) pq_mem[pq_wr] <= '{op: issue_op, id: PEND_ID_MAX'(issue_req_id)};
    if (reg_fire) begin
      rf_data[rf_wr] <= alu_res;
      rf_id[rf_wr]   <= head.id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pq_rd  <= '0;
      pq_wr  <= '0;
      pq_cnt <= '0;
      rf_rd  <= '0;
      rf_wr  <= '0;
      rf_cnt <= '0;
      err_id <= 1'b0;
    end else begin
      if (issue_fire) pq_wr <= pq_wr + PW'(1);
      if (reg_fire) begin
        pq_rd <= pq_rd + PW'(1);
        rf_wr <= rf_wr + PW'(1);
        if (PEND_ID_MAX'(register_id) != head.id) err_id <= 1'b1;
      end
      if (res_pop) rf_rd <= rf_rd + PW'(1);

      case ({issue_fire, reg_fire})
        2'b10:   pq_cnt <= pq_cnt + CW'(1);
        2'b01:   pq_cnt <= pq_cnt - CW'(1);
        default: pq_cnt <= pq_cnt;
      endcase

      case ({reg_fire, res_pop})
        2'b10:   rf_cnt <= rf_cnt + CW'(1);
        2'b01:   rf_cnt <= rf_cnt - CW'(1);
        default: rf_cnt <= rf_cnt;
      endcase
    end
  end

endmodule
